// File: rtl/time_counter.sv
// ---------------------------------------------------------------------------
// time_counter
//   Time-of-day counter (hh:mm:ss). A prescaler divides clk_i down to a
//   one-second tick, which advances seconds, minutes and hours with carries.
//   The time can be loaded from an external adjuster via a single-cycle strobe.
//   All outputs are registered, so no input reaches an output combinationally.
//
// Ports
//   clk_i       system clock, rising-edge active
//   rst_ni      asynchronous active-low reset
//   en_i        run enable (1 = time advances, 0 = time frozen)
//   load_i      load strobe; loads minute_i/hour_i and clears seconds
//   minute_i    minute value to load (values > 59 load as 0)
//   hour_i      hour value to load (values > 23 load as 0)
//   second_o    current seconds 0..59
//   minute_o    current minutes 0..59
//   hour_o      current hours 0..23
//   tick_o      one-cycle pulse after each second increment
//   rollover_o  one-cycle pulse after the wrap 23:59:59 -> 00:00:00
// ---------------------------------------------------------------------------
module time_counter #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [5:0] minute_i,
  input  logic [5:0] hour_i,
  output logic [5:0] second_o,
  output logic [5:0] minute_o,
  output logic [5:0] hour_o,
  output logic       tick_o,
  output logic       rollover_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] PRESCALE_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] prescale_q, prescale_d;
  logic [5:0]       second_q, second_d;
  logic [5:0]       minute_q, minute_d;
  logic [5:0]       hour_q, hour_d;
  logic             tick_q, tick_d;
  logic             rollover_q, rollover_d;

  // Next-state logic. A load wins over everything else and throws away a
  // tick that would have happened on the same edge. Otherwise, while
  // enabled, the prescaler counts up and its wrap cascades through the
  // seconds/minutes/hours carry chain in a single edge. The pulse outputs
  // default to 0 so they only ever last one cycle.
  always_comb begin
    prescale_d = prescale_q;
    second_d   = second_q;
    minute_d   = minute_q;
    hour_d     = hour_q;
    tick_d     = 1'b0;
    rollover_d = 1'b0;

    if (load_i) begin
      // Out-of-range load values are forced to 0 field by field.
      minute_d   = (minute_i > 6'd59) ? 6'd0 : minute_i;
      hour_d     = (hour_i > 6'd23) ? 6'd0 : hour_i;
      second_d   = 6'd0;
      prescale_d = '0;
    end else if (en_i) begin
      if (prescale_q == PRESCALE_LAST) begin
        prescale_d = '0;
        tick_d     = 1'b1;
        if (second_q >= 6'd59) begin
          second_d = 6'd0;
          if (minute_q >= 6'd59) begin
            minute_d = 6'd0;
            if (hour_q >= 6'd23) begin
              hour_d     = 6'd0;
              rollover_d = 1'b1;
            end else begin
              hour_d = hour_q + 6'd1;
            end
          end else begin
            minute_d = minute_q + 6'd1;
          end
        end else begin
          second_d = second_q + 6'd1;
        end
      end else begin
        prescale_d = prescale_q + CNT_W'(1);
      end
    end
  end

  // State register. Reset clears the whole time and the pulses at once,
  // without waiting for a clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescale_q <= '0;
      second_q   <= 6'd0;
      minute_q   <= 6'd0;
      hour_q     <= 6'd0;
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      second_q   <= second_d;
      minute_q   <= minute_d;
      hour_q     <= hour_d;
      tick_q     <= tick_d;
      rollover_q <= rollover_d;
    end
  end

  assign second_o   = second_q;
  assign minute_o   = minute_q;
  assign hour_o     = hour_q;
  assign tick_o     = tick_q;
  assign rollover_o = rollover_q;

endmodule
